// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with one-cycle rise/fall pulses
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  // Shift the async input through the chain; the history flop trails the last stage by one cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  // Synchroniser and history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~hist_q;
  assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - byte-oriented SPI mode-0 slave, oversampled in sys_clk
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       CS_N,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic [7:0] txd_data,
  output logic       MISO,
  output logic [7:0] rxd_data,
  output logic       rxd_flag,
  output logic       txd_flag
);

  localparam int BYTE_W = 8;

  logic cs_sync, cs_fall, cs_rise_unused;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]      rxd_data_q, rxd_data_d;
  logic                   miso_q, miso_d;
  logic                   rxd_flag_q, rxd_flag_d;
  logic                   txd_flag_q, txd_flag_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .din  (CS_N),
    .dout (cs_sync),
    .rise (cs_rise_unused),
    .fall (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .din  (SCK),
    .dout (sck_level_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // MOSI needs only the level chain, kept the same depth so it lines up with SCK edges
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Deselect dominates; select loads the first tx byte; SCK rise samples, SCK fall shifts or reloads
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rxd_data_d = rxd_data_q;
    miso_d     = miso_q;
    rxd_flag_d = 1'b0;
    txd_flag_d = 1'b0;
    if (cs_sync) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = '0;
      miso_d     = 1'b0;
    end else if (cs_fall) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = txd_data;
      miso_d     = txd_data[BYTE_W-1];
      txd_flag_d = 1'b1;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rxd_data_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
        rxd_flag_d = 1'b1;
      end
    end else if (sck_fall) begin
      if (bit_cnt_q == 3'd0) begin
        tx_shift_d = txd_data;
        miso_d     = txd_data[BYTE_W-1];
        txd_flag_d = 1'b1;
      end else begin
        tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        miso_d     = tx_shift_q[BYTE_W-2];
      end
    end
  end

  // Datapath and strobe registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rxd_data_q  <= '0;
      miso_q      <= 1'b0;
      rxd_flag_q  <= 1'b0;
      txd_flag_q  <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rxd_data_q  <= rxd_data_d;
      miso_q      <= miso_d;
      rxd_flag_q  <= rxd_flag_d;
      txd_flag_q  <= txd_flag_d;
    end
  end

  assign MISO     = miso_q;
  assign rxd_data = rxd_data_q;
  assign rxd_flag = rxd_flag_q;
  assign txd_flag = txd_flag_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - scoreboard bench for spi_slave_core
module tb_spi_slave_core;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       CS_N    = 1'b1;
  logic       SCK     = 1'b0;
  logic       MOSI    = 1'b0;
  logic [7:0] txd_data = 8'h00;
  logic       MISO;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  logic       txd_flag;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .CS_N    (CS_N),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .txd_data(txd_data),
    .MISO    (MISO),
    .rxd_data(rxd_data),
    .rxd_flag(rxd_flag),
    .txd_flag(txd_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  logic prev_rxf = 1'b0;
  logic prev_txf = 1'b0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] mosi_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected rx bytes on rxd_flag, plays the parent by advancing txd_data
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (rxd_flag) begin
        rx_cnt++;
        chk("rxd_flag one cycle", 32'(prev_rxf), 32'd0);
        chk("rxd_flag expected", 32'(exp_rx_q.size() > 0), 32'd1);
        if (exp_rx_q.size() > 0) chk("rxd_data", 32'(rxd_data), 32'(exp_rx_q.pop_front()));
        if (feed_q.size() > 0) txd_data = feed_q.pop_front();
      end
      if (txd_flag) begin
        tx_cnt++;
        chk("txd_flag one cycle", 32'(prev_txf), 32'd0);
      end
    end
    prev_rxf = rxd_flag;
    prev_txf = txd_flag;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // Master: sends mosi_q in one transaction; last byte may be cut short; CS_N rises with the final SCK fall
  task automatic spi_txn(input int h, input int last_bits, input bit check_miso);
    int n;
    logic [7:0] b;
    logic [7:0] cap;
    n = mosi_q.size();
    CS_N = 1'b0;
    for (int bi = 0; bi < n; bi++) begin
      int nb;
      b   = mosi_q.pop_front();
      nb  = (bi == n - 1) ? last_bits : 8;
      cap = 8'h00;
      for (int i = 0; i < nb; i++) begin
        MOSI = b[7-i];
        tick(h);
        cap = {cap[6:0], MISO};
        SCK = 1'b1;
        tick(h);
        SCK = 1'b0;
        if (bi == n - 1 && i == nb - 1) CS_N = 1'b1;
      end
      if (check_miso && nb == 8) chk("miso byte", 32'(cap), 32'(exp_miso_q.pop_front()));
    end
    MOSI = 1'b0;
    tick(12);
  endtask

  task automatic end_test(input string name, input int exp_rx, input int exp_tx);
    chk({name, " rxd_flag count"}, 32'(rx_cnt), 32'(exp_rx));
    chk({name, " txd_flag count"}, 32'(tx_cnt), 32'(exp_tx));
    chk({name, " rx queue drained"}, 32'(exp_rx_q.size()), 32'd0);
    rx_cnt = 0;
    tx_cnt = 0;
  endtask

  initial begin
    tick(3);
    chk("reset MISO", 32'(MISO), 32'd0);
    chk("reset rxd_data", 32'(rxd_data), 32'd0);
    chk("reset rxd_flag", 32'(rxd_flag), 32'd0);
    chk("reset txd_flag", 32'(txd_flag), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Single byte A5 in, 3C out
    txd_data = 8'h3C;
    mosi_q.push_back(8'hA5);
    exp_rx_q.push_back(8'hA5);
    exp_miso_q.push_back(8'h3C);
    spi_txn(5, 8, 1'b1);
    end_test("single", 1, 1);

    // Stream of three bytes, parent advances txd_data on rxd_flag
    txd_data = 8'h55;
    feed_q.push_back(8'hAA);
    feed_q.push_back(8'h7E);
    mosi_q.push_back(8'h55); mosi_q.push_back(8'hAA); mosi_q.push_back(8'h0F);
    exp_rx_q.push_back(8'h55); exp_rx_q.push_back(8'hAA); exp_rx_q.push_back(8'h0F);
    exp_miso_q.push_back(8'h55); exp_miso_q.push_back(8'hAA); exp_miso_q.push_back(8'h7E);
    spi_txn(5, 8, 1'b1);
    end_test("stream", 3, 3);

    // Abort after 5 bits, then a full byte C3
    txd_data = 8'hFF;
    mosi_q.push_back(8'h5A);
    spi_txn(5, 5, 1'b0);
    txd_data = 8'h99;
    mosi_q.push_back(8'hC3);
    exp_rx_q.push_back(8'hC3);
    exp_miso_q.push_back(8'h99);
    spi_txn(5, 8, 1'b1);
    end_test("abort", 1, 2);

    // SCK toggling while deselected
    for (int i = 0; i < 10; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCK  = 1'b1;
      tick(4);
      chk("idle MISO", 32'(MISO), 32'd0);
      SCK = 1'b0;
      tick(4);
    end
    tick(5);
    chk("idle rxd_data held", 32'(rxd_data), 32'hC3);
    end_test("idle", 0, 0);

    // Reset mid-byte
    txd_data = 8'hFF;
    CS_N = 1'b0;
    MOSI = 1'b1;
    tick(5);
    SCK = 1'b1;
    tick(5);
    SCK = 1'b0;
    tick(5);
    chk("pre-reset MISO", 32'(MISO), 32'd1);
    rst_n = 1'b0;
    CS_N  = 1'b1;
    MOSI  = 1'b0;
    #1;
    chk("mid reset MISO", 32'(MISO), 32'd0);
    chk("mid reset rxd_data", 32'(rxd_data), 32'd0);
    chk("mid reset rxd_flag", 32'(rxd_flag), 32'd0);
    chk("mid reset txd_flag", 32'(txd_flag), 32'd0);
    rx_cnt = 0;
    tx_cnt = 0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    end_test("post reset", 0, 0);

    // Max rate sys_clk/8, 213 bytes
    for (int i = 0; i < 213; i++) begin
      logic [7:0] rb;
      logic [7:0] tb;
      rb = 8'(i * 37 + 11);
      tb = 8'(i * 53 + 200) ^ 8'h5A;
      mosi_q.push_back(rb);
      exp_rx_q.push_back(rb);
      exp_miso_q.push_back(tb);
      if (i == 0) txd_data = tb;
      else feed_q.push_back(tb);
    end
    spi_txn(4, 8, 1'b1);
    end_test("max rate", 213, 213);
    chk("miso queue drained", 32'(exp_miso_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
